// File: rtl/fib_pkg.sv
// Shared types and defaults for the Fibonacci job sequencer slice.
package fib_pkg;

   localparam int FIB_WIDTH       = 32;
   localparam int FIB_DEPTH_DEF   = 4;
   localparam int FIB_TIMEOUT_DEF = 4096;

   typedef struct packed {
      logic [FIB_WIDTH-1:0] n;
      logic [FIB_WIDTH-1:0] a;
      logic [FIB_WIDTH-1:0] b;
   } job_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } seq_state_e;

endpackage

// File: rtl/fib_job_sequencer_if.sv
// Host job input, core handshake and result output of the job sequencer.
interface fib_job_sequencer_if #(
   parameter int WIDTH = fib_pkg::FIB_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_n;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             core_r_enable;
   logic [WIDTH-1:0] core_n;
   logic [WIDTH-1:0] core_a;
   logic [WIDTH-1:0] core_b;
   logic             core_w_enable;
   logic [WIDTH-1:0] core_result;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic [WIDTH-1:0] out_n;
   logic             out_timeout;
   logic             busy;
   logic [15:0]      jobs_done;

   // Environment side: host, Fibonacci core and result consumer.
   modport master (
      output in_valid, in_n, in_a, in_b, core_w_enable, core_result, out_ready,
      input  in_ready, core_r_enable, core_n, core_a, core_b,
             out_valid, out_result, out_n, out_timeout, busy, jobs_done
   );

   modport slave (
      input  in_valid, in_n, in_a, in_b, core_w_enable, core_result, out_ready,
      output in_ready, core_r_enable, core_n, core_a, core_b,
             out_valid, out_result, out_n, out_timeout, busy, jobs_done
   );
endinterface

// File: rtl/fib_job_fifo.sv
// Job descriptor FIFO; pointers carry a wrap bit to tell full from empty.
module fib_job_fifo
   import fib_pkg::*;
#(
   parameter int DEPTH = FIB_DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  job_t                   i_data,
   output job_t                   o_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   job_t        r_mem [DEPTH];
   logic        w_wr_en;
   logic        w_rd_en;

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign o_count = r_wr_ptr - r_rd_ptr;
   assign w_wr_en = i_push & ~o_full;
   assign w_rd_en = i_pop & ~o_empty;
   assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end
endmodule

// File: rtl/fib_job_sequencer.sv
// Feeds queued (n, a, b) jobs to the Fibonacci core one at a time and returns
// each result, abandoning jobs the core never finishes.
//
//   state | meaning
//   IDLE  | waiting for a queued job; head is loaded into core operands on exit
//   ISSUE | one-cycle start pulse to the core, watchdog cleared
//   WAIT  | waiting for a fresh rising edge of core_w_enable or watchdog expiry
//   HOLD  | result presented until the consumer accepts it
module fib_job_sequencer
   import fib_pkg::*;
#(
   parameter int WIDTH   = FIB_WIDTH,
   parameter int DEPTH   = FIB_DEPTH_DEF,
   parameter int TIMEOUT = FIB_TIMEOUT_DEF
) (
   input logic                clk,
   input logic                rst,
   fib_job_sequencer_if.slave bus
);
   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_ISSUE = ISSUE;
   localparam logic [1:0] ST_WAIT  = WAIT;
   localparam logic [1:0] ST_HOLD  = HOLD;

   localparam int             WD_W    = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   logic [1:0]             r_state;
   logic                   r_w_q;
   logic [WD_W-1:0]        r_wd;
   logic [WIDTH-1:0]       r_core_n;
   logic [WIDTH-1:0]       r_core_a;
   logic [WIDTH-1:0]       r_core_b;
   logic [WIDTH-1:0]       r_out_result;
   logic [WIDTH-1:0]       r_out_n;
   logic                   r_out_timeout;
   logic [15:0]            r_jobs_done;

   job_t                   w_in_job;
   job_t                   w_head;
   logic                   w_fifo_full;
   logic                   w_fifo_empty;
   logic [$clog2(DEPTH):0] w_fifo_count;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_done;
   logic [WD_W-1:0]        w_wd_next;
   logic                   w_expire;

   assign w_in_job = '{n: bus.in_n, a: bus.in_a, b: bus.in_b};
   assign w_push   = bus.in_valid & ~w_fifo_full;
   assign w_pop    = (r_state == ST_IDLE) & ~w_fifo_empty;

   fib_job_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_in_job),
      .o_data  (w_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   assign w_done    = bus.core_w_enable & ~r_w_q;
   assign w_wd_next = r_wd + {{(WD_W-1){1'b0}}, 1'b1};
   // Expiry is judged on the incremented count so the result lands exactly
   // TIMEOUT cycles after the start pulse.
   assign w_expire  = (w_wd_next == WD_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_w_q         <= 1'b0;
         r_wd          <= '0;
         r_core_n      <= '0;
         r_core_a      <= '0;
         r_core_b      <= '0;
         r_out_result  <= '0;
         r_out_n       <= '0;
         r_out_timeout <= 1'b0;
         r_jobs_done   <= '0;
      end else begin
         r_w_q <= bus.core_w_enable;
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_core_n <= w_head.n;
                  r_core_a <= w_head.a;
                  r_core_b <= w_head.b;
                  r_state  <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_wd    <= '0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (w_done) begin
                  r_out_result  <= bus.core_result;
                  r_out_n       <= r_core_n;
                  r_out_timeout <= 1'b0;
                  r_state       <= ST_HOLD;
               end else if (w_expire) begin
                  r_out_result  <= '0;
                  r_out_n       <= r_core_n;
                  r_out_timeout <= 1'b1;
                  r_state       <= ST_HOLD;
               end else begin
                  r_wd <= w_wd_next;
               end
            end
            ST_HOLD: begin
               if (bus.out_ready) begin
                  if (!r_out_timeout) r_jobs_done <= r_jobs_done + 16'd1;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready      = ~w_fifo_full;
   assign bus.core_r_enable = (r_state == ST_ISSUE);
   assign bus.core_n        = r_core_n;
   assign bus.core_a        = r_core_a;
   assign bus.core_b        = r_core_b;
   assign bus.out_valid     = (r_state == ST_HOLD);
   assign bus.out_result    = r_out_result;
   assign bus.out_n         = r_out_n;
   assign bus.out_timeout   = r_out_timeout;
   assign bus.busy          = (r_state != ST_IDLE) | (w_fifo_count != '0);
   assign bus.jobs_done     = r_jobs_done;
endmodule

// File: tb/tb_fib_job_sequencer.sv
// Directed bench for fib_job_sequencer with a behavioural Fibonacci core.
module tb_fib_job_sequencer;
   logic clk;
   logic rst;

   fib_job_sequencer_if #(.WIDTH(32)) bus ();

   fib_job_sequencer #(.WIDTH(32), .DEPTH(4), .TIMEOUT(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // core model state (updated on negedge, away from the DUT's sampling edge)
   logic        model_en = 1'b1;
   logic        m_mute   = 1'b0;
   int          m_delay  = 5;
   logic        m_run    = 1'b0;
   int          m_cnt    = 0;
   logic        m_w      = 1'b0;
   logic [31:0] m_res    = '0;
   logic        man_w    = 1'b0;
   logic [31:0] man_res  = '0;

   assign bus.core_w_enable = model_en ? m_w : man_w;
   assign bus.core_result   = model_en ? m_res : man_res;

   function automatic logic [31:0] fib_calc(input logic [31:0] n, input logic [31:0] a,
                                            input logic [31:0] b);
      logic [31:0] x, y, t;
      x = a;
      y = b;
      for (int i = 0; i < int'(n); i++) begin
         t = x + y;
         y = x;
         x = t;
      end
      return y;
   endfunction

   always @(negedge clk) begin
      if (bus.core_r_enable) begin
         m_cnt = m_delay;
         m_run = 1'b1;
         m_w   = 1'b0;
         m_res = fib_calc(bus.core_n, bus.core_a, bus.core_b);
      end else if (m_run && !m_mute) begin
         if (m_cnt == 0) begin
            m_w   = 1'b1;
            m_run = 1'b0;
         end else begin
            m_cnt = m_cnt - 1;
         end
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] n, input logic [31:0] a, input logic [31:0] b);
      int k = 0;
      bus.in_valid = 1'b1;
      bus.in_n = n;
      bus.in_a = a;
      bus.in_b = b;
      while (!bus.in_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      check_val("push_ready", bus.in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int max);
      int k = 0;
      while (!bus.out_valid && k < max) begin
         @(negedge clk);
         k++;
      end
      check_val(tag, bus.out_valid, 1);
   endtask

   task automatic wait_ren(input string tag);
      int k = 0;
      while (!bus.core_r_enable && k < 20) begin
         @(negedge clk);
         k++;
      end
      check_val(tag, bus.core_r_enable, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running, expected finished");
      $fatal(1, "bench time limit exceeded");
   end

   initial begin
      int          acc_at [5];
      logic [31:0] exp_fib [5];
      int          acc, cyc, cnt;
      logic        rdy;

      exp_fib = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd5};
      rst = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_n      = '0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;
      #3 rst = 1'b1;
      #1;
      check_val("rst_in_ready", bus.in_ready, 1);
      check_val("rst_out_valid", bus.out_valid, 0);
      check_val("rst_busy", bus.busy, 0);
      check_val("rst_jobs_done", bus.jobs_done, 0);
      check_val("rst_core_n", bus.core_n, 0);
      check_val("rst_r_enable", bus.core_r_enable, 0);
      check_val("rst_out_result", bus.out_result, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 1: single job, start latency and result
      push(32'd40, 32'd1, 32'd0);
      check_val("t1_ren_t1", bus.core_r_enable, 0);
      @(negedge clk);
      check_val("t1_ren_t2", bus.core_r_enable, 1);
      check_val("t1_core_n", bus.core_n, 40);
      @(negedge clk);
      check_val("t1_ren_pulse", bus.core_r_enable, 0);
      wait_valid("t1_valid", 100);
      check_val("t1_result", bus.out_result, 102334155);
      check_val("t1_out_n", bus.out_n, 40);
      check_val("t1_timeout", bus.out_timeout, 0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check_val("t1_valid_drop", bus.out_valid, 0);
      check_val("t1_jobs_done", bus.jobs_done, 1);

      // 2: five back-to-back pushes against a slow core
      m_delay = 8;
      acc = 0;
      cyc = 0;
      bus.in_valid = 1'b1;
      bus.in_a = 32'd1;
      bus.in_b = 32'd0;
      while (acc < 5 && cyc < 100) begin
         bus.in_n = 32'(acc + 1);
         rdy = bus.in_ready;
         @(posedge clk);
         if (rdy) begin
            acc_at[acc] = cyc;
            acc++;
         end
         cyc++;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      check_val("t2_accepted", acc, 5);
      for (int i = 0; i < 5; i++) check_val("t2_accept_cycle", acc_at[i], i);
      check_val("t2_full_ready", bus.in_ready, 0);
      check_val("t2_busy", bus.busy, 1);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_valid("t2_valid", 200);
         check_val("t2_out_n", bus.out_n, k + 1);
         check_val("t2_result", bus.out_result, exp_fib[k]);
         @(negedge clk);
      end
      check_val("t2_jobs_done", bus.jobs_done, 6);
      check_val("t2_ready_back", bus.in_ready, 1);
      bus.out_ready = 1'b0;

      // 3: consumer backpressure with a job waiting behind
      m_delay = 5;
      push(32'd10, 32'd1, 32'd0);
      wait_valid("t3_valid", 100);
      push(32'd6, 32'd1, 32'd0);
      for (int i = 0; i < 20; i++) begin
         check_val("t3_hold_valid", bus.out_valid, 1);
         check_val("t3_hold_result", bus.out_result, 55);
         check_val("t3_hold_n", bus.out_n, 10);
         check_val("t3_no_issue", bus.core_r_enable, 0);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check_val("t3_one_hshk", bus.out_valid, 0);
      check_val("t3_jobs_done", bus.jobs_done, 7);
      check_val("t3_gap_ren", bus.core_r_enable, 0);
      @(negedge clk);
      check_val("t3_next_ren", bus.core_r_enable, 1);
      check_val("t3_next_core_n", bus.core_n, 6);
      bus.out_ready = 1'b1;
      wait_valid("t3_valid2", 100);
      check_val("t3_result2", bus.out_result, 8);
      check_val("t3_out_n2", bus.out_n, 6);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check_val("t3_jobs_done2", bus.jobs_done, 8);

      // 4: watchdog expiry with a silent core
      m_mute = 1'b1;
      push(32'd7, 32'd1, 32'd0);
      wait_ren("t4_ren");
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!bus.out_valid && cnt < 300);
      check_val("t4_latency", cnt, 64);
      check_val("t4_timeout", bus.out_timeout, 1);
      check_val("t4_result", bus.out_result, 0);
      check_val("t4_out_n", bus.out_n, 7);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check_val("t4_valid_drop", bus.out_valid, 0);
      check_val("t4_jobs_done", bus.jobs_done, 8);
      m_mute = 1'b0;

      // 5: done level already high when WAIT is entered
      model_en = 1'b0;
      man_w = 1'b1;
      man_res = 32'd999;
      push(32'd12, 32'd1, 32'd0);
      wait_ren("t5_ren");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_val("t5_no_done", bus.out_valid, 0);
      end
      man_w = 1'b0;
      @(negedge clk);
      @(negedge clk);
      man_res = 32'd144;
      man_w = 1'b1;
      wait_valid("t5_valid", 20);
      check_val("t5_result", bus.out_result, 144);
      check_val("t5_out_n", bus.out_n, 12);
      check_val("t5_timeout", bus.out_timeout, 0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      man_w = 1'b0;
      check_val("t5_jobs_done", bus.jobs_done, 9);

      // 6: reset while waiting with two jobs queued
      push(32'd20, 32'd1, 32'd0);
      push(32'd21, 32'd1, 32'd0);
      push(32'd22, 32'd1, 32'd0);
      repeat (3) @(negedge clk);
      check_val("t6_busy_pre", bus.busy, 1);
      #2 rst = 1'b1;
      #1;
      check_val("t6_rst_valid", bus.out_valid, 0);
      check_val("t6_rst_busy", bus.busy, 0);
      check_val("t6_rst_ready", bus.in_ready, 1);
      check_val("t6_rst_core_n", bus.core_n, 0);
      check_val("t6_rst_jobs", bus.jobs_done, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      man_res = 32'd777;
      man_w = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 1) man_w = 1'b0;
         check_val("t6_no_valid", bus.out_valid, 0);
         check_val("t6_no_issue", bus.core_r_enable, 0);
      end
      model_en = 1'b1;
      m_delay = 3;
      bus.out_ready = 1'b1;
      push(32'd5, 32'd1, 32'd0);
      wait_valid("t6_valid", 100);
      check_val("t6_result", bus.out_result, 5);
      check_val("t6_out_n", bus.out_n, 5);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check_val("t6_jobs_done", bus.jobs_done, 1);
      check_val("t6_busy_end", bus.busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/fib_job_sequencer.md
Name: fib_job_sequencer

Overview:
Upstream stage for the `main` Fibonacci core. It accepts (n, a, b) job descriptors from a host over a valid/ready interface and buffers them in a small FIFO. It issues one job at a time to the core with a single-cycle `r_enable` pulse, waits for the core's `w_enable` rising edge, and returns the result over a valid/ready output. A watchdog flags jobs the core never completes.

Parameters:
- WIDTH, 32: width of n, a, b and result.
- DEPTH, 4: job FIFO depth; power of two, ≥2.
- TIMEOUT, 4096: maximum WAIT cycles before a job is abandoned.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  host job valid.
- in_ready  out  1  FIFO can accept (= !full; no same-cycle bypass).
- in_n, in_a, in_b  in  WIDTH each  job operands.
- core_r_enable  out  1  start pulse to core.
- core_n, core_a, core_b  out  WIDTH each  operands to core; registered.
- core_w_enable  in  1  core done level.
- core_result  in  WIDTH  core result, valid while core_w_enable is high.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_result  out  WIDTH  captured result (0 on timeout).
- out_n  out  WIDTH  n of the job that produced out_result.
- out_timeout  out  1  job abandoned by watchdog.
- busy  out  1  state != IDLE or FIFO non-empty.
- jobs_done  out  16  count of non-timeout results handed off; wraps at 65535→0.

Behaviour:
- Reset (async assert, sync release):
  - FIFO emptied; state IDLE.
  - All outputs 0, except in_ready=1.
  - core_* operand registers cleared.
- FIFO:
  - Push when in_valid & in_ready.
  - Pop only on the IDLE→ISSUE transition.
  - Full: in_ready=0, and in_valid is ignored (operands need not be held by this block).
  - Simultaneous push and pop when not full: both take effect; count unchanged.
- States:
  - IDLE: if FIFO is non-empty, pop the head into the core_n/a/b registers → ISSUE.
  - ISSUE: core_r_enable=1 for exactly this one cycle; clear the watchdog → WAIT.
  - WAIT:
    - Edge detect: sample core_w_enable into w_q each cycle. Done = core_w_enable & ~w_q.
    - On done: capture core_result into out_result, core_n into out_n, out_timeout=0 → HOLD.
    - Watchdog: otherwise increment it. At TIMEOUT-1 with no edge, set out_result=0 and out_timeout=1 → HOLD.
    - If done and timeout fall in the same cycle, done wins.
  - HOLD:
    - out_valid=1; out_result, out_n and out_timeout are stable until handshake.
    - On out_valid & out_ready: out_valid=0 next cycle, jobs_done+=1 unless out_timeout, → IDLE.
- Operand stability: core_n/a/b hold their value from ISSUE until the next IDLE→ISSUE load.
- Level handling: a core_w_enable level already high on entry to WAIT is not a completion; a fresh rising edge is required. w_q is updated in every state, so edges outside WAIT are ignored.
- Latency (empty FIFO, IDLE):
  - Push accepted in cycle t → core_r_enable high in cycle t+2.
  - Rising edge sampled in cycle u → out_valid high in cycle u+1.
- Minimum back-to-back spacing: 2 cycles from handshake to the next core_r_enable.
- Reset mid-operation: immediate return to IDLE with FIFO contents discarded. A core still running is left alone; its later w_enable edge is ignored because the state is not WAIT.
- busy: combinational from state and FIFO count.

Decomposition:
- Package fib_pkg:
  - FIB_WIDTH=32.
  - job_t struct {n, a, b}.
  - seq_state_e enum {IDLE, ISSUE, WAIT, HOLD}.
  - Default TIMEOUT constant.
- Sub-module fib_job_fifo: synchronous FIFO of job_t with push/pop/full/empty/count. Pointers carry an extra wrap bit; no read-during-write bypass.
- The FSM, watchdog, edge detector and output registers stay in fib_job_sequencer.

Test Plan:
1. Single job n=40, a=1, b=0 against a behavioural core model:
   - core_r_enable is a 1-cycle pulse 2 cycles after push.
   - out_result=102334155, out_n=40, out_timeout=0, jobs_done=1.
2. Five pushes on consecutive cycles while the core model is slow:
   - in_ready drops to 0 once 4 entries are held; the 5th is accepted after the first pop.
   - Results appear in push order (n=1,2,3,4,5).
3. Backpressure: out_ready held low 20 cycles during HOLD.
   - out_valid stays 1 and out_result/out_n stay stable; no new core_r_enable issues.
   - Releasing out_ready gives one handshake.
4. Timeout with TIMEOUT=64 and a core model that never asserts w_enable:
   - Exactly 64 cycles after ISSUE, out_valid=1, out_timeout=1, out_result=0.
   - jobs_done unchanged after the handshake.
5. Stuck level: core_w_enable held high from the prior job into the next WAIT.
   - No completion until it falls and rises again; the result is taken from the second edge.
6. rst asserted mid-WAIT with 2 jobs queued:
   - Outputs clear asynchronously and busy=0.
   - A later core w_enable pulse produces no out_valid.
   - A new push completes normally.
